// File: rtl/operand_a_unpack_pkg.sv
// Shared types and constants for the row-A operand path.
package operand_a_unpack_pkg;

  // Element precision of the A operand stream
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } prec_t;

  // Word-address width shared with the row-A address generator
  localparam int A_ADDR_W = 4;

  // Lane width in bits for each precision
  function automatic int lane_w(input prec_t p);
    case (p)
      FP32:    lane_w = 32;
      FP16:    lane_w = 16;
      INT8:    lane_w = 8;
      default: lane_w = 4;
    endcase
  endfunction

endpackage

// File: rtl/operand_a_unpack_fifo.sv
// Small register FIFO holding unpacked elements; DEPTH need not be a power of 2.
module unpack_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 33,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [W-1:0]     entry_reg [DEPTH];

  // Each entry captures data when the write pointer selects it
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg[gi] <= '0;
        end else if (!clr && push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Pointers wrap modulo DEPTH; count tracks push/pop balance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = entry_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/operand_a_unpack.sv
// Reads the A operand SRAM per (addr, sub) request, extracts one element by
// precision and streams it out through a credit-managed FIFO.
module operand_a_unpack
  import operand_a_unpack_pkg::*;
#(
  parameter int ADDR_W = A_ADDR_W,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  prec_t             prec,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_sub,
  input  logic              req_last,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic             acc;
  logic             inflight_reg;
  logic [2:0]       sub_reg;
  logic             last_reg;
  prec_t            prec_reg;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  logic [32:0]      fifo_head;
  logic [31:0]      elem_next;
  logic [CNT_W:0]   credits_used;

  // Credits: one per queued element plus one for the read in flight
  assign credits_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg);
  assign req_ready    = !flush && (credits_used < DEPTH_C);
  assign acc          = req_valid && req_ready;
  assign mem_rd_en    = acc;
  assign mem_rd_addr  = acc ? req_addr : '0;

  // Stage-1 metadata travels alongside the SRAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      sub_reg      <= '0;
      last_reg     <= 1'b0;
      prec_reg     <= FP32;
    end else begin
      inflight_reg <= acc;
      if (acc) begin
        sub_reg  <= req_sub;
        last_reg <= req_last;
        prec_reg <= prec;
      end
    end
  end

  // Lane extraction; lane 0 is the least-significant slice of the word
  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_lane;
    logic [3:0]  nib;
    half      = mem_rd_data[{sub_reg[0], 4'b0000} +: 16];
    byte_lane = mem_rd_data[{sub_reg[1:0], 3'b000} +: 8];
    nib       = mem_rd_data[{sub_reg, 2'b00} +: 4];
    elem_next = mem_rd_data[31:0];
    case (prec_reg)
      FP32:    elem_next = mem_rd_data[31:0];
      FP16:    elem_next = {16'b0, half};
      INT8:    elem_next = {{24{byte_lane[7]}}, byte_lane};
      default: elem_next = {{28{nib[3]}}, nib};
    endcase
  end

  // A returning read is dropped when flush lands in the same cycle
  assign push = inflight_reg && !flush;
  assign pop  = out_valid && out_ready;

  unpack_fifo #(
    .DEPTH (DEPTH),
    .W     (33)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push),
    .push_data ({last_reg, elem_next}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_head[31:0];
  assign out_last  = fifo_head[32];
  assign busy      = inflight_reg || (fifo_count != '0);

  // Precision must not change while elements are still in the pipe
  prec_stable_while_busy: assert property (
    @(posedge clk) disable iff (rst) ($past(busy) && busy) |-> (prec == $past(prec))
  );

endmodule

// File: tb/tb_operand_a_unpack.sv
// Directed bench for operand_a_unpack with a 1-cycle-latency SRAM model.
module tb_operand_a_unpack;
  import operand_a_unpack_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  prec_t       prec = FP32;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr = '0;
  logic [2:0]  req_sub = '0;
  logic        req_last = 1'b0;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  // SRAM model: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  operand_a_unpack dut (
    .clk         (clk),
    .rst         (rst),
    .prec        (prec),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_sub     (req_sub),
    .req_last    (req_last),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  typedef struct {
    prec_t       prec;
    logic [3:0]  addr;
    logic [2:0]  sub;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  initial begin
    int waited;
    int acc_cnt;
    int sent;
    int recvd;

    for (int a = 0; a < 16; a++) mem[a] = 32'hA0 + a;
    mem[5] = 32'h89AB_CDEF;

    for (int i = 0; i < 4; i++) vecs[i] = '{FP32, 4'(i), 3'd0, 32'hA0 + i};
    vecs[4]  = '{INT4, 4'd5, 3'd0, 32'hFFFF_FFFF};
    vecs[5]  = '{INT4, 4'd5, 3'd1, 32'hFFFF_FFFE};
    vecs[6]  = '{INT4, 4'd5, 3'd2, 32'hFFFF_FFFD};
    vecs[7]  = '{INT4, 4'd5, 3'd3, 32'hFFFF_FFFC};
    vecs[8]  = '{INT4, 4'd5, 3'd4, 32'hFFFF_FFFB};
    vecs[9]  = '{INT4, 4'd5, 3'd5, 32'hFFFF_FFFA};
    vecs[10] = '{INT4, 4'd5, 3'd6, 32'hFFFF_FFF9};
    vecs[11] = '{INT4, 4'd5, 3'd7, 32'hFFFF_FFF8};
    vecs[12] = '{INT8, 4'd5, 3'd4, 32'hFFFF_FFEF};
    vecs[13] = '{INT8, 4'd5, 3'd1, 32'hFFFF_FFCD};
    vecs[14] = '{INT8, 4'd5, 3'd2, 32'hFFFF_FFAB};
    vecs[15] = '{INT8, 4'd5, 3'd7, 32'hFFFF_FF89};
    vecs[16] = '{FP16, 4'd5, 3'd6, 32'h0000_CDEF};
    vecs[17] = '{FP16, 4'd5, 3'd1, 32'h0000_89AB};

    // Reset state
    step();
    step();
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("reset mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Table: one request at a time, drain before the next
    for (int i = 0; i < 18; i++) begin
      prec      = vecs[i].prec;
      req_addr  = vecs[i].addr;
      req_sub   = vecs[i].sub;
      req_valid = 1'b1;
      out_ready = 1'b1;
      step();
      req_valid = 1'b0;
      waited = 0;
      while (!out_valid && waited < 8) begin
        step();
        waited++;
      end
      if (!out_valid) check($sformatf("vec%0d timeout", i), 32'(out_valid), 32'd1);
      else check($sformatf("vec%0d data", i), out_data, vecs[i].exp);
      step();
    end

    // FP32 back-to-back stream: visible at N+2..N+5
    prec      = FP32;
    req_sub   = '0;
    out_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 4'd0;
    check("stream ready", 32'(req_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k < 4) begin
        req_addr = 4'(k);
        check($sformatf("stream ready k%0d", k), 32'(req_ready), 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      if (k == 1) check("stream latency", 32'(out_valid), 32'd0);
      else begin
        check($sformatf("stream valid k%0d", k), 32'(out_valid), 32'd1);
        check($sformatf("stream data k%0d", k), out_data, 32'hA0 + k - 2);
      end
    end
    step();
    check("stream drained", 32'(busy), 32'd0);

    // Backpressure: only DEPTH requests accepted
    out_ready = 1'b0;
    req_valid = 1'b1;
    acc_cnt   = 0;
    for (int c = 0; c < 6; c++) begin
      req_addr = 4'(acc_cnt);
      if (req_ready) acc_cnt++;
      step();
    end
    req_valid = 1'b0;
    check("bp accepted", 32'(acc_cnt), 32'd3);
    check("bp ready low", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    check("bp data0", out_data, 32'hA0);
    step();
    check("bp ready back", 32'(req_ready), 32'd1);
    check("bp data1", out_data, 32'hA1);
    step();
    check("bp data2", out_data, 32'hA2);
    step();
    check("bp empty", 32'(out_valid), 32'd0);

    // Flush with two queued and one read in flight
    out_ready = 1'b0;
    req_valid = 1'b1;
    acc_cnt   = 0;
    waited    = 0;
    while (acc_cnt < 3 && waited < 10) begin
      req_addr = 4'(acc_cnt);
      if (req_ready) acc_cnt++;
      step();
      waited++;
    end
    req_valid = 1'b0;
    check("flush setup", 32'(acc_cnt), 32'd3);
    flush = 1'b1;
    #1;
    check("flush ready low", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    step();
    step();
    check("flush no stale", 32'(out_valid), 32'd0);

    // Last marker under random output stalls
    sent  = 0;
    recvd = 0;
    for (int c = 0; c < 300 && recvd < 6; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      req_valid = (sent < 6);
      req_addr  = 4'(6 + sent);
      req_last  = (sent == 3);
      if (out_valid && out_ready) begin
        check($sformatf("last data%0d", recvd), out_data, 32'hA6 + recvd);
        check($sformatf("last flag%0d", recvd), 32'(out_last), 32'(recvd == 3));
        recvd++;
      end
      if (req_valid && req_ready) sent++;
      step();
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
    check("last received", 32'(recvd), 32'd6);
    out_ready = 1'b1;
    step();
    step();

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'd0;
    step();
    req_addr = 4'd1;
    step();
    req_valid = 1'b0;
    step();
    check("rst pre valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("rst stays empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
